// File: rtl/sdr_cas_read_capture.sv
`default_nettype none
// ============================================================================
//  Module   : sdr_cas_read_capture
//  Purpose  : Snoops the SDRAM command bus, decodes READ and BURST TERMINATE,
//             delays each command by its own CAS latency and captures dq for
//             a full burst. Supports interrupts and early termination.
//             Optional checking is enabled by defining
//             SDR_CAS_CAPTURE_CHECK_EN (illegal CAS and slot collision
//             drive rd_err).
//  Revision : 1.0  initial release
// ============================================================================
module sdr_cas_read_capture #(
   parameter int DQ_WIDTH  = 16,
   parameter int MAX_CAS   = 7,
   parameter int BURST_LEN = 4
) (
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic [2:0]                                          cfg_sdr_cas,
   input  logic                                                cs_n,
   input  logic                                                ras_n,
   input  logic                                                cas_n,
   input  logic                                                we_n,
   input  logic [DQ_WIDTH-1:0]                                 dq,
   output logic [DQ_WIDTH-1:0]                                 rd_data,
   output logic                                                rd_valid,
   output logic [((BURST_LEN > 1) ? $clog2(BURST_LEN) : 1)-1:0] rd_beat,
   output logic                                                rd_last,
   output logic                                                rd_err,
   output logic                                                busy
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [2:0]        c_MAX_CAS   = 3'(MAX_CAS);
   localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [BEAT_W-1:0] c_ONE       = BEAT_W'(1);
   localparam logic              c_KIND_READ = 1'b1;
   localparam logic              c_KIND_TERM = 1'b0;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Command decode
   // ------------------------------------------------------------------------
   logic w_cmd_read;
   logic w_cmd_term;
   logic w_cmd_any;
   logic w_cas_legal;
   logic w_cmd_ok;

   assign w_cmd_read  = ~cs_n & ras_n & ~cas_n & we_n;
   assign w_cmd_term  = ~cs_n & ras_n & cas_n & ~we_n;
   assign w_cmd_any   = w_cmd_read | w_cmd_term;
   assign w_cas_legal = (cfg_sdr_cas != 3'd0) && (cfg_sdr_cas <= c_MAX_CAS);
   // Commands with an illegal latency are dropped whether or not checking is built.
   assign w_cmd_ok    = w_cmd_any & w_cas_legal;

   // ------------------------------------------------------------------------
   // Token delay line: slot 0 is consumed by the beat engine each edge
   // ------------------------------------------------------------------------
   logic [MAX_CAS-1:0] tok_v_q, tok_v_d;
   logic [MAX_CAS-1:0] tok_k_q, tok_k_d;
   logic [MAX_CAS:0]   w_v_ext;
   logic [MAX_CAS:0]   w_k_ext;
   logic [MAX_CAS-1:0] w_shift_v;
   logic [MAX_CAS-1:0] w_shift_k;

   // Padding with an empty top entry keeps the shift legal even when MAX_CAS is 1.
   assign w_v_ext   = {1'b0, tok_v_q};
   assign w_k_ext   = {c_KIND_TERM, tok_k_q};
   assign w_shift_v = w_v_ext[MAX_CAS:1];
   assign w_shift_k = w_k_ext[MAX_CAS:1];

   // Shift the line and drop a new command into slot (latency - 1).
   always_comb begin
      tok_v_d = w_shift_v;
      tok_k_d = w_shift_k;
      if (w_cmd_ok) begin
         for (int i = 0; i < MAX_CAS; i++) begin
            if (cfg_sdr_cas == 3'(i + 1)) begin
               tok_v_d[i] = 1'b1;
               tok_k_d[i] = w_cmd_read ? c_KIND_READ : c_KIND_TERM;
            end
         end
      end
   end

   // Delay-line registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tok_v_q <= '0;
         tok_k_q <= '0;
      end else begin
         tok_v_q <= tok_v_d;
         tok_k_q <= tok_k_d;
      end
   end

   // ------------------------------------------------------------------------
   // Beat engine
   // ------------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   rem_q, rem_d;
   logic [BEAT_W-1:0]   rd_beat_q, rd_beat_d;
   logic [DQ_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_last_q, rd_last_d;
   logic [BEAT_W-1:0]   w_beat_inc;

   assign w_beat_inc = rd_beat_q + c_ONE;

   // Next state and next captured beat from the token leaving slot 0.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      rd_beat_d  = rd_beat_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      if (tok_v_q[0] && (tok_k_q[0] == c_KIND_READ)) begin
         // New burst, or an interrupt restarting at beat 0.
         state_d    = ST_BURST;
         rem_d      = c_LAST_BEAT;
         rd_beat_d  = '0;
         rd_data_d  = dq;
         rd_valid_d = 1'b1;
         rd_last_d  = (BURST_LEN == 1);
      end else if (tok_v_q[0]) begin
         // Terminate: suppress this and every later beat.
         state_d = ST_IDLE;
         rem_d   = '0;
      end else if ((state_q == ST_BURST) && (rem_q != '0)) begin
         rem_d      = rem_q - c_ONE;
         rd_beat_d  = w_beat_inc;
         rd_data_d  = dq;
         rd_valid_d = 1'b1;
         rd_last_d  = (w_beat_inc == c_LAST_BEAT);
      end else begin
         state_d = ST_IDLE;
         rem_d   = '0;
      end
   end

   // Beat engine state and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         rd_beat_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         rd_beat_q  <= rd_beat_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_beat  = rd_beat_q;
   assign rd_last  = rd_last_q;
   assign busy     = (|tok_v_q) | (state_q == ST_BURST);

   // ------------------------------------------------------------------------
   // Protocol checking
   // ------------------------------------------------------------------------
`ifdef SDR_CAS_CAPTURE_CHECK_EN
   logic w_coll;
   logic rd_err_q, rd_err_d;

   // A collision means the targeted slot already holds a shifted token.
   always_comb begin
      w_coll = 1'b0;
      for (int i = 0; i < MAX_CAS; i++) begin
         if (cfg_sdr_cas == 3'(i + 1)) begin
            w_coll = w_shift_v[i];
         end
      end
   end

   assign rd_err_d = (w_cmd_any & ~w_cas_legal) | (w_cmd_ok & w_coll);

   // One-cycle error pulse, registered at the offending command edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_err_q <= 1'b0;
      end else begin
         rd_err_q <= rd_err_d;
      end
   end

   assign rd_err = rd_err_q;
`else
   assign rd_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdr_cas_read_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdr_cas_read_capture
//  Purpose  : Directed vector table, reset sequence and randomized traffic
//             compared against an event-schedule reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdr_cas_read_capture;

   localparam int DQW  = 16;
   localparam int MAXC = 7;
   localparam int BL   = 4;
   localparam int N    = 4096;
   localparam int NR   = 2500;
`ifdef SDR_CAS_CAPTURE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic           clk;
   logic           reset;
   logic [2:0]     cfg_sdr_cas;
   logic           cs_n, ras_n, cas_n, we_n;
   logic [DQW-1:0] dq;
   logic [DQW-1:0] rd_data;
   logic           rd_valid;
   logic [1:0]     rd_beat;
   logic           rd_last;
   logic           rd_err;
   logic           busy;

   sdr_cas_read_capture #(
      .DQ_WIDTH  (DQW),
      .MAX_CAS   (MAXC),
      .BURST_LEN (BL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_sdr_cas (cfg_sdr_cas),
      .cs_n        (cs_n),
      .ras_n       (ras_n),
      .cas_n       (cas_n),
      .we_n        (we_n),
      .dq          (dq),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_beat     (rd_beat),
      .rd_last     (rd_last),
      .rd_err      (rd_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // cmd: 0 = deselect, 1 = READ, 2 = TERM
   task automatic drive(input int cmd, input int c, input int d);
      cfg_sdr_cas = 3'(c);
      dq          = DQW'(d);
      cs_n  = (cmd == 0);
      ras_n = 1'b1;
      cas_n = (cmd != 1);
      we_n  = (cmd != 2);
   endtask

   typedef struct {
      int   cmd;
      int   cas;
      int   dqv;
      logic v;
      int   d;
      int   beat;
      logic last;
      logic err;
      logic bsy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int cmd, int cas, int dqv, logic v, int d, int beat,
                               logic last, logic err, logic bsy);
      vec_t r;
      r.cmd = cmd; r.cas = cas; r.dqv = dqv; r.v = v; r.d = d; r.beat = beat;
      r.last = last; r.err = err; r.bsy = bsy;
      return r;
   endfunction

   // Reference model: events scheduled by absolute edge, beats laid out per edge.
   bit sv[N];
   bit sk[N];
   bit ev[N];
   int eb[N];

   initial begin
      int        r;
      logic      is_rd, is_tm, exp_err, exp_busy;
      int        c, t;
      logic [15:0] dv;

      reset = 1'b1;
      drive(0, 2, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 32'(rd_valid), 0);
      chk("reset_data",  32'(rd_data), 0);
      chk("reset_beat",  32'(rd_beat), 0);
      chk("reset_last",  32'(rd_last), 0);
      chk("reset_err",   32'(rd_err), 0);
      chk("reset_busy",  32'(busy), 0);
      reset = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // CL=2 plain burst
      tbl.push_back(mk(1, 2, 0,      0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 0,      0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hA000, 1, 'hA000, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hA001, 1, 'hA001, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hA002, 1, 'hA002, 2, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hA003, 1, 'hA003, 3, 1, 0, 1));
      tbl.push_back(mk(0, 2, 'h1111, 0, 0,      0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 0,      0, 0,      0, 0, 0, 0));
      // CL=3 read interrupt
      tbl.push_back(mk(1, 3, 'hB000, 0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(0, 3, 'hB001, 0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(1, 3, 'hB002, 0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(0, 3, 'hB003, 1, 'hB003, 0, 0, 0, 1));
      tbl.push_back(mk(0, 3, 'hB004, 1, 'hB004, 1, 0, 0, 1));
      tbl.push_back(mk(0, 3, 'hB005, 1, 'hB005, 0, 0, 0, 1));
      tbl.push_back(mk(0, 3, 'hB006, 1, 'hB006, 1, 0, 0, 1));
      tbl.push_back(mk(0, 3, 'hB007, 1, 'hB007, 2, 0, 0, 1));
      tbl.push_back(mk(0, 3, 'hB008, 1, 'hB008, 3, 1, 0, 1));
      tbl.push_back(mk(0, 3, 'hB009, 0, 0,      0, 0, 0, 0));
      // CL=2 READ then TERM
      tbl.push_back(mk(1, 2, 'hD000, 0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(2, 2, 'hD001, 0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hD002, 1, 'hD002, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hD003, 0, 0,      0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 'hD004, 0, 0,      0, 0, 0, 0));
      // Collision: CL=3 then CL=2 targeting the same edge
      tbl.push_back(mk(1, 3, 'hC000, 0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(1, 2, 'hC001, 0, 0,      0, 0, 1, 1));
      tbl.push_back(mk(0, 2, 'hC002, 0, 0,      0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hC003, 1, 'hC003, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hC004, 1, 'hC004, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hC005, 1, 'hC005, 2, 0, 0, 1));
      tbl.push_back(mk(0, 2, 'hC006, 1, 'hC006, 3, 1, 0, 1));
      tbl.push_back(mk(0, 2, 'hC007, 0, 0,      0, 0, 0, 0));
      // Illegal CAS 0
      tbl.push_back(mk(1, 0, 'hE000, 0, 0,      0, 0, 1, 0));
      tbl.push_back(mk(0, 2, 'hE001, 0, 0,      0, 0, 0, 0));
      tbl.push_back(mk(0, 2, 'hE002, 0, 0,      0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].cmd, tbl[i].cas, tbl[i].dqv);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(tbl[i].v));
         if (tbl[i].v) begin
            chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(tbl[i].d));
            chk($sformatf("vec%0d_beat", i), 32'(rd_beat), 32'(tbl[i].beat));
         end
         chk($sformatf("vec%0d_last", i), 32'(rd_last), 32'(tbl[i].last));
         chk($sformatf("vec%0d_err", i),  32'(rd_err),  32'(CHK && tbl[i].err));
         chk($sformatf("vec%0d_busy", i), 32'(busy),    32'(tbl[i].bsy));
      end

      // Reset mid-burst: CL=2 READ, reset after the second beat
      drive(1, 2, 'hF000);
      @(posedge clk); #1;
      drive(0, 2, 'hF001);
      @(posedge clk); #1;
      drive(0, 2, 'hF002);
      @(posedge clk); #1;
      chk("rst_seq_beat0", 32'(rd_valid), 1);
      drive(0, 2, 'hF003);
      @(posedge clk); #1;
      chk("rst_seq_beat1", 32'(rd_beat), 1);
      reset = 1'b1;
      #1;
      chk("rst_seq_valid", 32'(rd_valid), 0);
      chk("rst_seq_data",  32'(rd_data), 0);
      chk("rst_seq_beat",  32'(rd_beat), 0);
      chk("rst_seq_last",  32'(rd_last), 0);
      chk("rst_seq_err",   32'(rd_err), 0);
      chk("rst_seq_busy",  32'(busy), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("rst_seq_after_valid", 32'(rd_valid), 0);
         chk("rst_seq_after_busy",  32'(busy), 0);
      end

      // Randomized traffic against the event-schedule model
      for (int e = 0; e < NR; e++) begin
         r = int'($urandom_range(0, 99));
         c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MAXC));
         dv = 16'($urandom);
         if (r < 25)      drive(1, c, dv);
         else if (r < 33) drive(2, c, dv);
         else             drive(0, c, dv);
         if (r >= 33 && r < 40) begin
            {cs_n, ras_n, cas_n, we_n} = 4'($urandom);
         end
         is_rd = !cs_n && ras_n && !cas_n && we_n;
         is_tm = !cs_n && ras_n && cas_n && !we_n;
         @(posedge clk);
         #1;
         exp_err = 1'b0;
         if (is_rd || is_tm) begin
            if (c == 0 || c > MAXC) begin
               exp_err = CHK;
            end else begin
               t = e + c;
               if (sv[t]) exp_err = CHK;
               sv[t] = 1'b1;
               sk[t] = is_rd;
            end
         end
         if (sv[e]) begin
            for (int n = 0; n < BL; n++) begin
               ev[e+n] = sk[e];
               eb[e+n] = n;
            end
            sv[e] = 1'b0;
         end
         exp_busy = ev[e];
         for (int j = 1; j <= MAXC; j++) if (sv[e+j]) exp_busy = 1'b1;
         chk("rnd_valid", 32'(rd_valid), 32'(ev[e]));
         if (ev[e]) begin
            chk("rnd_data", 32'(rd_data), 32'(dv));
            chk("rnd_beat", 32'(rd_beat), 32'(eb[e]));
         end
         chk("rnd_last", 32'(rd_last), 32'(ev[e] && eb[e] == BL - 1));
         chk("rnd_err",  32'(rd_err),  32'(exp_err));
         chk("rnd_busy", 32'(busy),    32'(exp_busy));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
